// File: rtl/saradc_11b_pkg.sv
// Shared types and constants for the SAR ADC digital blocks, including the
// conversion scheduler state encoding and its default limits.
package saradc_11b_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        CONV  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } sched_state_e;

    localparam int SCHED_N_REQ_MAX   = 8;
    localparam int SCHED_TIMEOUT_DEF = 1023;

    // Width of a requester index; never below one bit.
    function automatic int sched_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/saradc_11b_conv_sched_if.sv
// Requester and ADC-side signal bundle of the conversion scheduler.
// slave is the scheduler view, master is the requester/ADC environment view.
interface saradc_11b_conv_sched_if #(
    parameter int N_REQ    = 4,
    parameter int CHNR_W   = 4,
    parameter int RESULT_W = 16
);
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ*CHNR_W-1:0] req_chnr_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [N_REQ-1:0]        done_o;
    logic [N_REQ-1:0]        err_o;
    logic [RESULT_W-1:0]     result_o;
    logic                    sched_idle_o;
    logic                    mod_ready_i;
    logic                    busy_i;
    logic                    eoc_i;
    logic [RESULT_W-1:0]     adc_result_i;
    logic                    start_adc_o;
    logic [CHNR_W-1:0]       chnr_o;

    modport slave (
        input  req_i, req_chnr_i, mod_ready_i, busy_i, eoc_i, adc_result_i,
        output gnt_o, done_o, err_o, result_o, sched_idle_o, start_adc_o, chnr_o
    );

    modport master (
        output req_i, req_chnr_i, mod_ready_i, busy_i, eoc_i, adc_result_i,
        input  gnt_o, done_o, err_o, result_o, sched_idle_o, start_adc_o, chnr_o
    );
endinterface

// File: rtl/saradc_11b_rr_arb.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Returns a one-hot grant and the winner index; the pointer lives in the caller.
module saradc_11b_rr_arb
    import saradc_11b_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = sched_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] w_cand [N_REQ];

    // w_cand[i] is the requester examined at scan offset i from the pointer.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign w_cand[gi] = IDX_W'((int'(ptr) + gi) % N_REQ);
        end
    endgenerate

    // Scan from the far end so the lowest offset is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[w_cand[i]]) begin
                idx = w_cand[i];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (|req) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/saradc_11b_conv_sched.sv
// Shares one SAR ADC between N_REQ requesters: round-robin grant, start/busy/eoc
// tracking, result or error return. Optional watchdog: SARADC_11B_SCHED_TIMEOUT_EN.
module saradc_11b_conv_sched
    import saradc_11b_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int CHNR_W      = 4,
    parameter int RESULT_W    = 16,
    parameter int TIMEOUT_CYC = SCHED_TIMEOUT_DEF
) (
    input  logic                    clk_i,
    input  logic                    res_i,
    saradc_11b_conv_sched_if.slave  sched_bus
);

    localparam int IDX_W = sched_idx_w(N_REQ);

    sched_state_e        r_state;
    sched_state_e        w_state_next;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_owner;
    logic [CHNR_W-1:0]   r_chnr;
    logic [RESULT_W-1:0] r_result;
    logic [N_REQ-1:0]    r_gnt;

    logic [N_REQ-1:0]    w_arb_gnt;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_arb_go;
    logic                w_abort;
    logic                w_timeout;
    logic [N_REQ-1:0]    w_owner_hot;

    saradc_11b_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .req (sched_bus.req_i),
        .ptr (r_ptr),
        .gnt (w_arb_gnt),
        .idx (w_arb_idx)
    );

    assign w_arb_go = sched_bus.mod_ready_i & ~sched_bus.busy_i & (|sched_bus.req_i);
    assign w_abort  = ~sched_bus.mod_ready_i | w_timeout;

`ifdef SARADC_11B_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wdog;

    // Counter value equals cycles spent since START entry; the limit is hit on
    // the edge that would take it to TIMEOUT_CYC.
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            r_wdog <= '0;
        end else if (r_state == IDLE) begin
            r_wdog <= '0;
        end else if (r_state == START || r_state == CONV) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_timeout = (r_wdog == WD_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // eoc is checked first so it wins over a concurrent abort or timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb_go) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (sched_bus.eoc_i) begin
                    w_state_next = DONE;
                end else if (w_abort) begin
                    w_state_next = ERR;
                end else if (sched_bus.busy_i) begin
                    w_state_next = CONV;
                end
            end
            CONV: begin
                if (sched_bus.eoc_i) begin
                    w_state_next = DONE;
                end else if (w_abort) begin
                    w_state_next = ERR;
                end
            end
            DONE:    w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            r_ptr    <= '0;
            r_owner  <= '0;
            r_chnr   <= '0;
            r_result <= '0;
            r_gnt    <= '0;
        end else begin
            r_gnt <= '0;
            if (r_state == IDLE && w_arb_go) begin
                r_owner <= w_arb_idx;
                r_chnr  <= sched_bus.req_chnr_i[int'(w_arb_idx) * CHNR_W +: CHNR_W];
                r_ptr   <= (w_arb_idx == IDX_W'(N_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
                r_gnt   <= w_arb_gnt;
            end
            if ((r_state == START || r_state == CONV) && sched_bus.eoc_i) begin
                r_result <= sched_bus.adc_result_i;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_owner_hot
            assign w_owner_hot[gi] = (r_owner == IDX_W'(gi));
        end
    endgenerate

    assign sched_bus.gnt_o        = r_gnt;
    assign sched_bus.done_o       = (r_state == DONE) ? w_owner_hot : '0;
    assign sched_bus.err_o        = (r_state == ERR)  ? w_owner_hot : '0;
    assign sched_bus.result_o     = r_result;
    assign sched_bus.sched_idle_o = (r_state == IDLE);
    assign sched_bus.start_adc_o  = (r_state == START);
    assign sched_bus.chnr_o       = r_chnr;

endmodule

// File: tb/tb_saradc_11b_conv_sched.sv
// Randomized bench for saradc_11b_conv_sched: acts as requesters and ADC, and
// predicts grants/results from a round-robin reference with a plain pointer.
module tb_saradc_11b_conv_sched;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    saradc_11b_conv_sched_if #(.N_REQ(N), .CHNR_W(4), .RESULT_W(16)) sif ();

    saradc_11b_conv_sched #(
        .N_REQ       (N),
        .CHNR_W      (4),
        .RESULT_W    (16),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk_i     (clk),
        .res_i     (rst),
        .sched_bus (sif.slave)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          ptr_m = 0;
    logic [15:0] res_m = '0;
    logic [3:0]  ch_m [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int i = 0; i < N; i++) begin
            if (m[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    // Apply a request mask, wait for the grant and check it against the model.
    task automatic request(input logic [3:0] mask, input bit new_ch, output int w);
        bit seen;
        if (new_ch) begin
            for (int k = 0; k < N; k++) ch_m[k] = 4'($urandom_range(0, 15));
        end
        sif.req_chnr_i = {ch_m[3], ch_m[2], ch_m[1], ch_m[0]};
        sif.req_i      = mask;
        w    = rr_pick(mask, ptr_m);
        seen = 1'b0;
        for (int t = 0; t < 4 && !seen; t++) begin
            @(negedge clk);
            if (sif.gnt_o != '0) seen = 1'b1;
        end
        chk("gnt_seen", 32'(seen), 32'd1);
        chk("gnt", 32'(sif.gnt_o), 32'd1 << w);
        chk("chnr", 32'(sif.chnr_o), 32'(ch_m[w]));
        chk("start", 32'(sif.start_adc_o), 32'd1);
        ptr_m = (w + 1) % N;
        $display("grant mask=%b -> owner %0d chnr %0d", mask, w, ch_m[w]);
    endtask

    // mode 0: eoc in CONV, 1: mod_ready abort, 2: eoc with mod_ready low, 3: eoc in START
    task automatic run_txn(input logic [3:0] mask, input bit new_ch, input bit hold,
                           input int d_busy, input int n_conv, input int mode,
                           input logic [15:0] res);
        int w;
        request(mask, new_ch, w);
        if (!hold) sif.req_i = '0;
        if (mode != 3) begin
            for (int i = 0; i < d_busy; i++) @(negedge clk);
            chk("start_hold", 32'(sif.start_adc_o), 32'd1);
            if (d_busy > 0) chk("gnt_pulse", 32'(sif.gnt_o), 32'd0);
            sif.busy_i = 1'b1;
            for (int i = 0; i < n_conv; i++) begin
                @(negedge clk);
                if (i == 0) chk("conv_nostart", 32'(sif.start_adc_o), 32'd0);
            end
        end
        if (mode != 1) begin
            sif.eoc_i        = 1'b1;
            sif.adc_result_i = res;
        end
        if (mode == 1 || mode == 2) sif.mod_ready_i = 1'b0;
        @(negedge clk);
        if (mode == 1) begin
            chk("err", 32'(sif.err_o), 32'd1 << w);
            chk("err_nodone", 32'(sif.done_o), 32'd0);
        end else begin
            res_m = res;
            chk("done", 32'(sif.done_o), 32'd1 << w);
            chk("done_noerr", 32'(sif.err_o), 32'd0);
        end
        chk("result", 32'(sif.result_o), 32'(res_m));
        $display("txn owner %0d mode %0d done=%b err=%b result=%h", w, mode,
                 sif.done_o, sif.err_o, sif.result_o);
        sif.eoc_i        = 1'b0;
        sif.busy_i       = 1'b0;
        sif.mod_ready_i  = 1'b1;
        sif.adc_result_i = 16'($urandom);
        @(negedge clk);
        chk("back_idle", 32'({sif.sched_idle_o, sif.done_o, sif.err_o}), 32'h100);
    endtask

    initial begin
        int  w;
        bit  flag;
        sif.req_i        = '0;
        sif.req_chnr_i   = '0;
        sif.mod_ready_i  = 1'b1;
        sif.busy_i       = 1'b0;
        sif.eoc_i        = 1'b0;
        sif.adc_result_i = '0;
        for (int k = 0; k < N; k++) ch_m[k] = '0;

        repeat (2) @(negedge clk);
        chk("rst_outs", 32'({sif.gnt_o, sif.done_o, sif.err_o, sif.start_adc_o, sif.sched_idle_o}), 32'd1);
        chk("rst_result", 32'(sif.result_o), 32'd0);
        chk("rst_chnr", 32'(sif.chnr_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request, channel 5, result 0x0ABC.
        ch_m[1] = 4'd5;
        run_txn(4'b0010, 1'b0, 1'b0, 0, 3, 0, 16'h0ABC);

        // Fairness from pointer 0 with all four requesting.
        run_txn(4'b1000, 1'b1, 1'b0, 1, 1, 0, 16'h1111);
        for (int i = 0; i < 8; i++) begin
            run_txn(4'b1111, i == 0, i != 7, 0, 2, 0, 16'($urandom));
        end

        // Wrap: pointer at 3, requests 0 and 2.
        run_txn(4'b0100, 1'b1, 1'b0, 0, 1, 0, 16'h2222);
        run_txn(4'b0101, 1'b1, 1'b1, 0, 1, 0, 16'h3333);
        run_txn(4'b0101, 1'b0, 1'b0, 0, 1, 0, 16'h4444);

        // Abort two cycles into CONV, race, and eoc while still in START.
        run_txn(4'b0110, 1'b1, 1'b0, 1, 2, 1, 16'hDEAD);
        run_txn(4'b1001, 1'b1, 1'b0, 0, 2, 2, 16'h5A5A);
        run_txn(4'b0010, 1'b1, 1'b0, 0, 1, 3, 16'hC3C3);

        // Watchdog: eoc never arrives.
        request(4'b0001, 1'b1, w);
        sif.req_i  = '0;
        sif.busy_i = 1'b1;
`ifdef SARADC_11B_SCHED_TIMEOUT_EN
        flag = 1'b0;
        for (int k = 1; k < 15; k++) begin
            @(negedge clk);
            if (sif.err_o != '0 || sif.sched_idle_o) flag = 1'b1;
        end
        chk("wd_early", 32'(flag), 32'd0);
        @(negedge clk);
        chk("wd_err", 32'(sif.err_o), 32'd1 << w);
        chk("wd_result", 32'(sif.result_o), 32'(res_m));
        $display("watchdog err=%b", sif.err_o);
        sif.busy_i = 1'b0;
        @(negedge clk);
        chk("wd_idle", 32'(sif.sched_idle_o), 32'd1);
`else
        flag = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sif.err_o != '0 || sif.done_o != '0 || sif.sched_idle_o) flag = 1'b0;
        end
        chk("no_wd_stuck", 32'(flag), 32'd1);
        $display("no watchdog: still converting after 40 cycles");
        sif.eoc_i        = 1'b1;
        sif.adc_result_i = 16'h7777;
        @(negedge clk);
        res_m = 16'h7777;
        chk("no_wd_done", 32'(sif.done_o), 32'd1 << w);
        sif.eoc_i  = 1'b0;
        sif.busy_i = 1'b0;
        @(negedge clk);
`endif

        // Asynchronous reset mid-CONV.
        request(4'b0100, 1'b1, w);
        sif.req_i  = '0;
        sif.busy_i = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_outs", 32'({sif.gnt_o, sif.done_o, sif.err_o, sif.start_adc_o, sif.sched_idle_o}), 32'd1);
        chk("arst_result", 32'(sif.result_o), 32'd0);
        chk("arst_chnr", 32'(sif.chnr_o), 32'd0);
        $display("async reset mid-conversion idle=%b", sif.sched_idle_o);
        ptr_m = 0;
        res_m = '0;
        sif.busy_i = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (sif.done_o != '0 || sif.err_o != '0) flag = 1'b1;
        end
        chk("arst_nopulse", 32'(flag), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            run_txn(4'($urandom_range(1, 15)), 1'b1, 1'b0, $urandom_range(0, 3),
                    $urandom_range(1, 5), $urandom_range(0, 3), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
